// File: rtl/reorder_buffer_if.sv
// Dispatcher, CDB, regfile-commit, LSB-release and rollback signals of the reorder buffer.
// slave is the buffer's view of the bundle; master is the surrounding machine's view.
interface reorder_buffer_if;
    logic        en_signal_from_dispatcher;
    logic [4:0]  rd_from_dispatcher;
    logic        is_store_from_dispatcher;
    logic        is_branch_from_dispatcher;
    logic        pred_jump_from_dispatcher;
    logic        full_to_dispatcher;
    logic [4:0]  Q_to_dispatcher;
    logic [4:0]  Q1_from_dispatcher;
    logic [4:0]  Q2_from_dispatcher;
    logic        ready1_to_dispatcher;
    logic        ready2_to_dispatcher;
    logic [31:0] V1_to_dispatcher;
    logic [31:0] V2_to_dispatcher;
    logic        cdb_valid_in;
    logic [4:0]  cdb_Q_in;
    logic [31:0] cdb_V_in;
    logic        cdb_jump_in;
    logic [31:0] cdb_pc_in;
    logic        commit_flag_to_regfile;
    logic [4:0]  rd_to_regfile;
    logic [4:0]  Q_to_regfile;
    logic [31:0] V_to_regfile;
    logic        commit_store_to_lsb;
    logic [4:0]  store_Q_to_lsb;
    logic        rollback_flag_out;
    logic [31:0] target_pc_out;

    modport slave (
        input  en_signal_from_dispatcher, rd_from_dispatcher, is_store_from_dispatcher,
               is_branch_from_dispatcher, pred_jump_from_dispatcher,
               Q1_from_dispatcher, Q2_from_dispatcher,
               cdb_valid_in, cdb_Q_in, cdb_V_in, cdb_jump_in, cdb_pc_in,
        output full_to_dispatcher, Q_to_dispatcher,
               ready1_to_dispatcher, ready2_to_dispatcher, V1_to_dispatcher, V2_to_dispatcher,
               commit_flag_to_regfile, rd_to_regfile, Q_to_regfile, V_to_regfile,
               commit_store_to_lsb, store_Q_to_lsb, rollback_flag_out, target_pc_out
    );

    modport master (
        output en_signal_from_dispatcher, rd_from_dispatcher, is_store_from_dispatcher,
               is_branch_from_dispatcher, pred_jump_from_dispatcher,
               Q1_from_dispatcher, Q2_from_dispatcher,
               cdb_valid_in, cdb_Q_in, cdb_V_in, cdb_jump_in, cdb_pc_in,
        input  full_to_dispatcher, Q_to_dispatcher,
               ready1_to_dispatcher, ready2_to_dispatcher, V1_to_dispatcher, V2_to_dispatcher,
               commit_flag_to_regfile, rd_to_regfile, Q_to_regfile, V_to_regfile,
               commit_store_to_lsb, store_Q_to_lsb, rollback_flag_out, target_pc_out
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates at tail, captures CDB results, retires head, flushes on mispredict.
// Latency: CDB at edge N -> registered commit pulse after edge N+1; operand queries are combinational with CDB bypass.
// Backpressure: full_to_dispatcher at ROB_SIZE entries; rdy_in low freezes all state.
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int IDX_W    = 4
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    reorder_buffer_if.slave bus
);
    localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(ROB_SIZE);
    localparam logic [IDX_W:0]   ONE_CNT  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROB_SIZE - 1);

    logic [ROB_SIZE-1:0] busy, ready, is_store, is_branch, pred_jump, jump;
    logic [4:0]          rd  [ROB_SIZE];
    logic [31:0]         val [ROB_SIZE];
    logic [31:0]         pc  [ROB_SIZE];
    logic [IDX_W-1:0]    head, tail;
    logic [IDX_W:0]      count;

    logic             full, do_alloc, do_commit, mispredict, cdb_hit;
    logic [IDX_W-1:0] cdb_idx;
    logic [32:0]      q1_res, q2_res;

    function automatic logic [IDX_W-1:0] inc(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    function automatic logic [4:0] tag_of(input logic [IDX_W-1:0] i);
        return 5'(i) + 5'd1;
    endfunction

    function automatic logic in_range(input logic [4:0] t);
        return (t != 5'd0) && (int'(t) <= ROB_SIZE);
    endfunction

    // Returns {ready, value}; a result on the CDB this cycle takes priority over the stored one.
    function automatic logic [32:0] lookup(input logic [4:0] t, input logic cv,
                                           input logic [4:0] cq, input logic [31:0] cval);
        logic [IDX_W-1:0] i;
        i = IDX_W'(t - 5'd1);
        if (t == 5'd0)              return '0;
        if (cv && cq == t)          return {1'b1, cval};
        if (!in_range(t))           return '0;
        return {ready[i], val[i]};
    endfunction

    assign full       = (count == FULL_CNT);
    assign do_commit  = busy[head] && ready[head];
    assign mispredict = do_commit && is_branch[head] && (jump[head] != pred_jump[head]);
    assign do_alloc   = bus.en_signal_from_dispatcher && !full && !mispredict;
    assign cdb_idx    = IDX_W'(bus.cdb_Q_in - 5'd1);
    assign cdb_hit    = bus.cdb_valid_in && in_range(bus.cdb_Q_in) && busy[cdb_idx];

    always_comb begin
        q1_res = lookup(bus.Q1_from_dispatcher, bus.cdb_valid_in, bus.cdb_Q_in, bus.cdb_V_in);
        q2_res = lookup(bus.Q2_from_dispatcher, bus.cdb_valid_in, bus.cdb_Q_in, bus.cdb_V_in);
    end

    assign bus.full_to_dispatcher   = full;
    assign bus.Q_to_dispatcher      = tag_of(tail);
    assign bus.ready1_to_dispatcher = q1_res[32];
    assign bus.V1_to_dispatcher     = q1_res[31:0];
    assign bus.ready2_to_dispatcher = q2_res[32];
    assign bus.V2_to_dispatcher     = q2_res[31:0];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            busy      <= '0;
            ready     <= '0;
            is_store  <= '0;
            is_branch <= '0;
            pred_jump <= '0;
            jump      <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                rd[i]  <= '0;
                val[i] <= '0;
                pc[i]  <= '0;
            end
            bus.commit_flag_to_regfile <= 1'b0;
            bus.rd_to_regfile          <= '0;
            bus.Q_to_regfile           <= '0;
            bus.V_to_regfile           <= '0;
            bus.commit_store_to_lsb    <= 1'b0;
            bus.store_Q_to_lsb         <= '0;
            bus.rollback_flag_out      <= 1'b0;
            bus.target_pc_out          <= '0;
        end else begin
            bus.commit_flag_to_regfile <= 1'b0;
            bus.commit_store_to_lsb    <= 1'b0;
            bus.rollback_flag_out      <= 1'b0;
            if (rdy_in) begin
                if (cdb_hit) begin
                    ready[cdb_idx] <= 1'b1;
                    val[cdb_idx]   <= bus.cdb_V_in;
                    jump[cdb_idx]  <= bus.cdb_jump_in;
                    pc[cdb_idx]    <= bus.cdb_pc_in;
                end
                if (do_alloc) begin
                    busy[tail]      <= 1'b1;
                    ready[tail]     <= 1'b0;
                    rd[tail]        <= bus.rd_from_dispatcher;
                    is_store[tail]  <= bus.is_store_from_dispatcher;
                    is_branch[tail] <= bus.is_branch_from_dispatcher;
                    pred_jump[tail] <= bus.pred_jump_from_dispatcher;
                    tail            <= inc(tail);
                end
                if (do_commit) begin
                    bus.commit_flag_to_regfile <= 1'b1;
                    bus.rd_to_regfile          <= rd[head];
                    bus.Q_to_regfile           <= tag_of(head);
                    bus.V_to_regfile           <= val[head];
                    if (is_store[head]) begin
                        bus.commit_store_to_lsb <= 1'b1;
                        bus.store_Q_to_lsb      <= tag_of(head);
                    end
                    busy[head] <= 1'b0;
                    head       <= inc(head);
                end
                // A mispredicted branch still retires, then everything younger is dropped.
                if (mispredict) begin
                    busy                  <= '0;
                    head                  <= '0;
                    tail                  <= '0;
                    count                 <= '0;
                    bus.rollback_flag_out <= 1'b1;
                    bus.target_pc_out     <= pc[head];
                end else begin
                    case ({do_alloc, do_commit})
                        2'b10:   count <= count + ONE_CNT;
                        2'b01:   count <= count - ONE_CNT;
                        default: count <= count;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against a program-order queue model.
module tb_reorder_buffer;
    localparam int ROB = 16;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;

    reorder_buffer_if bus();

    reorder_buffer #(.ROB_SIZE(ROB), .IDX_W(4)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .bus(bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [4:0]  tag;
        logic [4:0]  rd;
        logic        st, br, pred, done, jmp;
        logic [31:0] v, pc;
    } ent_t;

    ent_t q[$];
    int   next_tag;
    int   total = 0;
    int   bad   = 0;

    logic        exp_cf, exp_cs, exp_rb;
    logic [4:0]  exp_rd, exp_q, exp_sq;
    logic [31:0] exp_v, exp_tpc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rdy_in                        = 1'b1;
        bus.en_signal_from_dispatcher = 1'b0;
        bus.rd_from_dispatcher        = '0;
        bus.is_store_from_dispatcher  = 1'b0;
        bus.is_branch_from_dispatcher = 1'b0;
        bus.pred_jump_from_dispatcher = 1'b0;
        bus.Q1_from_dispatcher        = '0;
        bus.Q2_from_dispatcher        = '0;
        bus.cdb_valid_in              = 1'b0;
        bus.cdb_Q_in                  = '0;
        bus.cdb_V_in                  = '0;
        bus.cdb_jump_in               = 1'b0;
        bus.cdb_pc_in                 = '0;
    endtask

    function automatic logic [32:0] qmodel(input logic [4:0] t);
        if (t == 5'd0) return '0;
        if (bus.cdb_valid_in && bus.cdb_Q_in == t) return {1'b1, bus.cdb_V_in};
        foreach (q[i]) if (q[i].tag == t) return {q[i].done, q[i].v};
        return '0;
    endfunction

    task automatic check_regs();
        chk("commit_flag", bus.commit_flag_to_regfile, exp_cf);
        chk("commit_rd", bus.rd_to_regfile, exp_rd);
        chk("commit_Q", bus.Q_to_regfile, exp_q);
        chk("commit_V", bus.V_to_regfile, exp_v);
        chk("store_flag", bus.commit_store_to_lsb, exp_cs);
        chk("store_Q", bus.store_Q_to_lsb, exp_sq);
        chk("rollback", bus.rollback_flag_out, exp_rb);
        chk("target_pc", bus.target_pc_out, exp_tpc);
    endtask

    // Applies one clock edge's worth of the buffer's rules to the program-order queue.
    task automatic model_step();
        logic com, mis, was_full;
        ent_t h, n;
        exp_cf = 1'b0;
        exp_cs = 1'b0;
        exp_rb = 1'b0;
        if (!rdy_in) return;
        was_full = (q.size() == ROB);
        com = (q.size() > 0) && q[0].done;
        if (com) h = q[0];
        mis = com && h.br && (h.jmp != h.pred);
        if (bus.cdb_valid_in)
            foreach (q[i])
                if (q[i].tag == bus.cdb_Q_in) begin
                    q[i].done = 1'b1;
                    q[i].v    = bus.cdb_V_in;
                    q[i].jmp  = bus.cdb_jump_in;
                    q[i].pc   = bus.cdb_pc_in;
                end
        if (bus.en_signal_from_dispatcher && !was_full && !mis) begin
            n.tag  = 5'(next_tag);
            n.rd   = bus.rd_from_dispatcher;
            n.st   = bus.is_store_from_dispatcher;
            n.br   = bus.is_branch_from_dispatcher;
            n.pred = bus.pred_jump_from_dispatcher;
            n.done = 1'b0;
            n.jmp  = 1'b0;
            n.v    = '0;
            n.pc   = '0;
            q.push_back(n);
            next_tag = (next_tag == ROB) ? 1 : next_tag + 1;
        end
        if (com) begin
            exp_cf = 1'b1;
            exp_rd = h.rd;
            exp_q  = h.tag;
            exp_v  = h.v;
            if (h.st) begin
                exp_cs = 1'b1;
                exp_sq = h.tag;
            end
            void'(q.pop_front());
            if (mis) begin
                exp_rb   = 1'b1;
                exp_tpc  = h.pc;
                q.delete();
                next_tag = 1;
            end
        end
    endtask

    task automatic cycle();
        logic [32:0] e;
        #1;
        chk("full", bus.full_to_dispatcher, q.size() == ROB);
        chk("next_tag", bus.Q_to_dispatcher, next_tag);
        e = qmodel(bus.Q1_from_dispatcher);
        chk("ready1", bus.ready1_to_dispatcher, e[32]);
        if (e[32]) chk("V1", bus.V1_to_dispatcher, e[31:0]);
        e = qmodel(bus.Q2_from_dispatcher);
        chk("ready2", bus.ready2_to_dispatcher, e[32]);
        if (e[32]) chk("V2", bus.V2_to_dispatcher, e[31:0]);
        @(posedge clk_in);
        #1;
        model_step();
        check_regs();
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        q.delete();
        next_tag = 1;
        exp_cf = 0; exp_cs = 0; exp_rb = 0;
        exp_rd = 0; exp_q = 0; exp_sq = 0; exp_v = 0; exp_tpc = 0;
        check_regs();
        chk("rst_full", bus.full_to_dispatcher, 1'b0);
        chk("rst_next_tag", bus.Q_to_dispatcher, 5'd1);
    endtask

    task automatic alloc(input logic [4:0] rd, input logic st, input logic br, input logic pred);
        idle();
        bus.en_signal_from_dispatcher = 1'b1;
        bus.rd_from_dispatcher        = rd;
        bus.is_store_from_dispatcher  = st;
        bus.is_branch_from_dispatcher = br;
        bus.pred_jump_from_dispatcher = pred;
        cycle();
    endtask

    task automatic cdb(input logic [4:0] t, input logic [31:0] v, input logic j, input logic [31:0] pc);
        idle();
        bus.cdb_valid_in = 1'b1;
        bus.cdb_Q_in     = t;
        bus.cdb_V_in     = v;
        bus.cdb_jump_in  = j;
        bus.cdb_pc_in    = pc;
        cycle();
    endtask

    function automatic logic [4:0] pick();
        int r;
        r = $urandom_range(3);
        if (r == 0 || q.size() == 0) return bus.cdb_valid_in ? bus.cdb_Q_in : 5'd0;
        if (r == 1) return 5'd0;
        return q[$urandom_range(q.size() - 1)].tag;
    endfunction

    initial begin
        int pend[$];
        int k;

        // In-order retirement of out-of-order results
        do_reset();
        alloc(5'd5, 0, 0, 0);
        alloc(5'd6, 0, 0, 0);
        alloc(5'd7, 0, 0, 0);
        cdb(5'd3, 32'h33, 0, 0);
        cdb(5'd1, 32'h11, 0, 0);
        cdb(5'd2, 32'h22, 0, 0);
        repeat (4) begin idle(); cycle(); end

        // Fill, ignored 17th request, wrap of the tag back to 1
        do_reset();
        for (int i = 0; i < ROB; i++) alloc(5'(i), 0, 0, 0);
        alloc(5'd9, 0, 0, 0);
        chk("full_hold", bus.full_to_dispatcher, 1'b1);
        cdb(5'd1, 32'hA1, 0, 0);
        idle(); cycle();
        chk("wrap_tag", bus.Q_to_dispatcher, 5'd1);
        alloc(5'd3, 0, 0, 0);

        // Mispredicted branch at the head flushes younger work
        do_reset();
        alloc(5'd1, 0, 1, 0);
        alloc(5'd2, 0, 0, 0);
        alloc(5'd3, 0, 0, 0);
        cdb(5'd2, 32'h2, 0, 0);
        cdb(5'd3, 32'h3, 0, 0);
        cdb(5'd1, 32'h44, 1, 32'h100);
        repeat (3) begin idle(); cycle(); end
        alloc(5'd8, 0, 0, 0);

        // Operand query with CDB bypass and tag 0
        do_reset();
        alloc(5'd1, 0, 0, 0);
        alloc(5'd2, 0, 0, 0);
        idle();
        bus.cdb_valid_in       = 1'b1;
        bus.cdb_Q_in           = 5'd2;
        bus.cdb_V_in           = 32'hABCD;
        bus.Q1_from_dispatcher = 5'd2;
        bus.Q2_from_dispatcher = 5'd0;
        cycle();

        // Store release to the LSB
        do_reset();
        alloc(5'd1, 0, 0, 0);
        alloc(5'd2, 0, 0, 0);
        alloc(5'd3, 0, 0, 0);
        alloc(5'd0, 1, 0, 0);
        for (int t = 1; t <= 4; t++) cdb(5'(t), 32'(t * 16), 0, 0);
        repeat (4) begin idle(); cycle(); end

        // Global stall with a ready head
        do_reset();
        alloc(5'd4, 0, 0, 0);
        cdb(5'd1, 32'h77, 0, 0);
        repeat (3) begin idle(); rdy_in = 1'b0; cycle(); end
        idle(); cycle();
        idle(); cycle();

        // Random traffic
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            idle();
            rdy_in = ($urandom_range(9) != 0);
            if ((q.size() < ROB) ? ($urandom_range(9) < 6) : ($urandom_range(9) == 0)) begin
                bus.en_signal_from_dispatcher = 1'b1;
                bus.rd_from_dispatcher        = 5'($urandom_range(31));
                bus.is_store_from_dispatcher  = ($urandom_range(4) == 0);
                bus.is_branch_from_dispatcher = !bus.is_store_from_dispatcher && ($urandom_range(3) == 0);
                bus.pred_jump_from_dispatcher = 1'($urandom_range(1));
            end
            pend.delete();
            foreach (q[i]) if (!q[i].done) pend.push_back(i);
            if ($urandom_range(9) < 6) begin
                bus.cdb_valid_in = 1'b1;
                bus.cdb_V_in     = $urandom;
                bus.cdb_pc_in    = $urandom;
                bus.cdb_jump_in  = 1'($urandom_range(1));
                if (pend.size() > 0 && $urandom_range(7) != 0) begin
                    k = pend[$urandom_range(pend.size() - 1)];
                    bus.cdb_Q_in = q[k].tag;
                    if (q[k].br) bus.cdb_jump_in = ($urandom_range(3) == 0) ? !q[k].pred : q[k].pred;
                end else begin
                    bus.cdb_Q_in = 5'($urandom_range(ROB));
                end
            end
            bus.Q1_from_dispatcher = pick();
            bus.Q2_from_dispatcher = pick();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
